// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet controller: state encoding, default
// frame parameters and the running-checksum helper.
package uart_pkt_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_LEN   = 3'd2;
    localparam state_t ST_DATA  = 3'd3;
    localparam state_t ST_CHK   = 3'd4;
    localparam state_t ST_DRAIN = 3'd5;

    localparam int         MAX_LEN_DEF   = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CHK_W         = 8;

    function automatic logic [CHK_W-1:0] chk_fold(input logic [CHK_W-1:0] acc,
                                                  input logic [7:0]       data);
        return acc ^ data;
    endfunction

    // A depth of one still needs a one-bit pointer.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, one write port, combinational read.
module uart_pkt_buf
    import uart_pkt_pkg::*;
#(
    parameter int DEPTH = MAX_LEN_DEF,
    parameter int AW    = idx_width(MAX_LEN_DEF)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Sync-hunting frame parser (A5 addr len payload chk) that releases payload
// only after the XOR checksum verifies. UART_PKT_TIMEOUT_EN adds an inter-byte gap abort.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN   = MAX_LEN_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
`ifdef UART_PKT_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CLKS = 20000
`endif
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Data_Valid,
    input  logic       i_Data_Ready,
    output logic [7:0] o_Data,
    output logic       o_Data_Last,
    output logic [7:0] o_Addr,
    output logic       o_Drop,
    output logic [7:0] o_Err_Cnt
);

    localparam int IDX_W = idx_width(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [7:0]       err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rd_q, rd_d;
    logic             drop_q, drop_d;

    logic             buf_we;
    logic [7:0]       buf_rdata;
    logic             timeout;
    logic             err_inc;
    logic             rd_last;
    logic             len_bad;
    state_t           byte_state;

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TO_W-1:0] gap_q, gap_d;
    logic            gap_active;

    assign gap_active = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                        (state_q == ST_DATA) || (state_q == ST_CHK);
    assign timeout    = gap_active && (gap_q == TO_W'(TIMEOUT_CLKS));

    always_comb begin
        gap_d = gap_q + 1'b1;
        if (i_Rx_DV || !gap_active || timeout) begin
            gap_d = '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A byte landing on the timeout cycle is parsed as if the FSM were already idle.
    assign byte_state = timeout ? ST_IDLE : state_q;
    assign rd_last    = (8'(rd_q) == (len_q - 8'd1));
    assign len_bad    = (i_Rx_Byte == 8'd0) || (int'(i_Rx_Byte) > MAX_LEN);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        buf_we  = 1'b0;
        err_inc = timeout;
        drop_d  = (state_q == ST_DRAIN) && i_Rx_DV;

        if (timeout) begin
            state_d = ST_IDLE;
        end

        if (state_q == ST_DRAIN) begin
            if (i_Data_Ready) begin
                if (rd_last) begin
                    state_d = ST_IDLE;
                    rd_d    = '0;
                end else begin
                    rd_d = rd_q + 1'b1;
                end
            end
        end else if (i_Rx_DV) begin
            case (byte_state)
                ST_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_d  = i_Rx_Byte;
                    chk_d   = i_Rx_Byte;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (len_bad) begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = i_Rx_Byte;
                        chk_d   = chk_fold(chk_q, i_Rx_Byte);
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    buf_we = 1'b1;
                    chk_d  = chk_fold(chk_q, i_Rx_Byte);
                    if (8'(idx_q) == (len_q - 8'd1)) begin
                        state_d = ST_CHK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_CHK: begin
                    if (i_Rx_Byte == chk_q) begin
                        rd_d    = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        err_d = err_q;
        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IDX_W)
    ) u_buf (
        .clk_i   (i_Clock),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (i_Rx_Byte),
        .raddr_i (rd_q),
        .rdata_o (buf_rdata)
    );

    assign o_Data_Valid = (state_q == ST_DRAIN);
    assign o_Data       = o_Data_Valid ? buf_rdata : 8'd0;
    assign o_Data_Last  = o_Data_Valid && rd_last;
    assign o_Addr       = addr_q;
    assign o_Drop       = drop_q;
    assign o_Err_Cnt    = err_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: frame-level model feeds a beat scoreboard
// checked every cycle, plus hand-computed literal checks.
module tb_uart_rx_pkt_ctrl;

    localparam int MAX_LEN = 16;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [7:0] a;
    } beat_t;

    logic       i_Clock      = 1'b0;
    logic       i_Rst_n      = 1'b0;
    logic       i_Rx_DV      = 1'b0;
    logic [7:0] i_Rx_Byte    = 8'd0;
    logic       i_Data_Ready = 1'b1;
    logic       o_Data_Valid;
    logic [7:0] o_Data;
    logic       o_Data_Last;
    logic [7:0] o_Addr;
    logic       o_Drop;
    logic [7:0] o_Err_Cnt;

    int    n_checks  = 0;
    int    n_fail    = 0;
    int    exp_err   = 0;
    int    exp_drop  = 0;
    int    drop_seen = 0;
    beat_t exp_q[$];

    uart_rx_pkt_ctrl dut (
        .i_Clock      (i_Clock),
        .i_Rst_n      (i_Rst_n),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Data_Valid (o_Data_Valid),
        .i_Data_Ready (i_Data_Ready),
        .o_Data       (o_Data),
        .o_Data_Last  (o_Data_Last),
        .o_Addr       (o_Addr),
        .o_Drop       (o_Drop),
        .o_Err_Cnt    (o_Err_Cnt)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] l,
                                             input bytes_t pl);
        logic [7:0] c;
        c = a ^ l;
        foreach (pl[i]) c = c ^ pl[i];
        return c;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Stimulus tasks enter and leave 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(posedge i_Clock); #1;
        i_Rx_DV   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_Clock); #1;
        end
    endtask

    task automatic push_payload(input logic [7:0] a, input bytes_t pl);
        foreach (pl[i]) exp_q.push_back('{d: pl[i], last: (i == pl.size() - 1), a: a});
    endtask

    // Frame-level model: a frame is delivered iff its length is legal and the checksum matches.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input bytes_t pl,
                              input logic [7:0] corrupt);
        logic [7:0] c;
        c = frame_chk(a, l, pl) ^ corrupt;
        send_byte(8'hA5);
        send_byte(a);
        send_byte(l);
        if (l == 8'd0 || int'(l) > MAX_LEN) begin
            exp_err = sat_inc(exp_err);
        end else begin
            foreach (pl[i]) send_byte(pl[i]);
            if (corrupt == 8'd0) push_payload(a, pl);
            else exp_err = sat_inc(exp_err);
            send_byte(c);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge i_Clock); #1;
            k++;
        end
        check({name, "_drain_timeout"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, o_Data_Valid, 0);
        check({name, "_data"}, o_Data, 0);
        check({name, "_last"}, o_Data_Last, 0);
        check({name, "_addr"}, o_Addr, 0);
        check({name, "_drop"}, o_Drop, 0);
        check({name, "_err"}, o_Err_Cnt, 0);
    endtask

    // Per-cycle scoreboard: every transfer must match the model, held data must not move.
    initial begin
        logic       prev_valid, prev_ready, prev_last;
        logic [7:0] prev_data;
        beat_t      e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge i_Clock);
            if (!i_Rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", o_Data_Valid, 1);
                    check("hold_data", o_Data, prev_data);
                    check("hold_last", o_Data_Last, prev_last);
                end
                if (o_Data_Valid && i_Data_Ready) begin
                    $display("beat addr=%02h data=%02h last=%0d", o_Addr, o_Data, o_Data_Last);
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", o_Data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", o_Data, e.d);
                        check("beat_last", o_Data_Last, e.last);
                        check("beat_addr", o_Addr, e.a);
                    end
                end
                if (o_Drop) drop_seen++;
                prev_valid = o_Data_Valid;
                prev_ready = i_Data_Ready;
                prev_last  = o_Data_Last;
                prev_data  = o_Data;
            end
        end
    end

    initial begin
        bytes_t pl;

        repeat (3) @(posedge i_Clock);
        #1;
        check_outputs_zero("reset");
        i_Rst_n = 1'b1;
        idle(1);

        // Good frame with literal timing: beats on the three clocks after the CHK byte.
        pl = '{8'h11, 8'h22, 8'h33};
        check("model_chk_pin", frame_chk(8'h10, 8'h03, pl), 8'h13);
        send_frame(8'h10, 8'h03, pl, 8'h00);
        @(negedge i_Clock);
        check("good_b0_valid", o_Data_Valid, 1);
        check("good_b0_data", o_Data, 8'h11);
        check("good_b0_last", o_Data_Last, 0);
        check("good_addr", o_Addr, 8'h10);
        @(negedge i_Clock);
        check("good_b1_data", o_Data, 8'h22);
        @(negedge i_Clock);
        check("good_b2_data", o_Data, 8'h33);
        check("good_b2_last", o_Data_Last, 1);
        @(negedge i_Clock);
        check("good_after_valid", o_Data_Valid, 0);
        @(posedge i_Clock); #1;
        wait_drain("good");
        check("good_err", o_Err_Cnt, 0);

        // Bad checksum 0x14, then a good frame.
        send_frame(8'h10, 8'h03, pl, 8'h07);
        idle(2);
        check("badchk_valid", o_Data_Valid, 0);
        check("badchk_err", o_Err_Cnt, exp_err);
        check("badchk_err_pin", o_Err_Cnt, 1);
        pl = '{8'hAB, 8'hCD};
        send_frame(8'h20, 8'h02, pl, 8'h00);
        wait_drain("after_bad");
        check("after_bad_err", o_Err_Cnt, exp_err);

        // Length boundaries with leading garbage.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        pl.delete();
        send_frame(8'h10, 8'h00, pl, 8'h00);
        check("len0_err", o_Err_Cnt, exp_err);
        send_byte(8'h12);
        send_frame(8'h10, 8'h11, pl, 8'h00);
        check("len17_err", o_Err_Cnt, exp_err);
        check("len_err_pin", o_Err_Cnt, 3);
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 7 + 1));
        send_frame(8'h31, 8'(MAX_LEN), pl, 8'h00);
        wait_drain("lenmax");
        pl = '{8'h5C};
        send_frame(8'h32, 8'h01, pl, 8'h00);
        wait_drain("len1");
        check("len_ok_err", o_Err_Cnt, exp_err);

        // Backpressure for 5 clocks with a sync byte strobed mid-drain.
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_frame(8'h44, 8'h04, pl, 8'h00);
        idle(1);
        i_Data_Ready = 1'b0;
        idle(2);
        send_byte(8'hA5);
        exp_drop++;
        idle(2);
        i_Data_Ready = 1'b1;
        wait_drain("bp");
        idle(2);
        check("bp_drop_count", drop_seen, exp_drop);
        check("bp_err", o_Err_Cnt, exp_err);

        // Long gap inside DATA: the frame still completes.
        pl = '{8'h11, 8'h22};
        push_payload(8'h10, pl);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
        idle(100);
        send_byte(8'h22);
        send_byte(frame_chk(8'h10, 8'h02, pl));
        wait_drain("gap");
        check("gap_err", o_Err_Cnt, exp_err);

        // Error counter saturation.
        pl = '{8'h55};
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h01, 8'h01, pl, 8'h01);
            check("sat_err", o_Err_Cnt, exp_err);
        end
        check("sat_err_pin", o_Err_Cnt, 255);

        // Reset in the middle of DATA, then a clean frame.
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        i_Rst_n = 1'b0;
        idle(1);
        check_outputs_zero("midreset");
        exp_err = 0;
        exp_q.delete();
        i_Rst_n = 1'b1;
        idle(1);
        pl = '{8'h9A, 8'hBC};
        send_frame(8'h66, 8'h02, pl, 8'h00);
        wait_drain("post_reset");
        check("post_reset_err", o_Err_Cnt, 0);

        idle(2);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_drop_count", drop_seen, exp_drop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
